pll_lock_sequencer: RTL and testbench
=====================================

Name: pll_lock_sequencer

Overview:
Reset/lock sequencer for the system clock PLL (50 MHz ref -> 28/56/14/7/112/140 MHz outputs). It runs on the free-running 50 MHz reference and drives the PLL's active-high reset. It qualifies the PLL lock output and releases the design's reset domains in stages. It also handles lock-loss recovery, lock timeouts with bounded retry, and relock requests, e.g. after a video timing or machine change.

Parameters:
RESET_CYCLES, 16, refclk cycles that pll_rst is held high per attempt (>=1)
LOCK_STABLE_CYCLES, 1024, consecutive synchronized-lock cycles required before release (>=1)
LOCK_TIMEOUT, 65536, refclk cycles allowed in WAIT_LOCK before the attempt is abandoned (>LOCK_STABLE_CYCLES)
STAGE_GAP, 16, cycles between periph_rst_n release and core_rst_n release (>=1)
MAX_RETRIES, 3, failed lock attempts before FAULT (1..15)

Ports:
refclk  in  1  50 MHz reference clock; all logic on rising edge
rst_n  in  1  synchronous active-low reset
locked  in  1  PLL lock, asynchronous to refclk
relock_req  in  1  single-cycle request to re-run the PLL bring-up
pll_rst  out  1  to PLL rst, active high
periph_rst_n  out  1  active-low reset for peripheral/video domain, released first
core_rst_n  out  1  active-low reset for CPU/core domain, released last
ready  out  1  high only in RUN
fault  out  1  high only in FAULT
retries  out  4  failed attempts since last RUN or relock_req

Behaviour:
- Sampling and synchronization
  - rst_n is sampled on refclk; rst_n low wins over every other event.
  - locked passes through a 2-flop synchronizer (lock_s), so it has 2 cycles of latency. Only lock_s is used internally.
- Reset state (rst_n low at an edge): state=PLL_RST, all counters 0, synchronizer 0, pll_rst=1, periph_rst_n=0, core_rst_n=0, ready=0, fault=0, retries=0.
- All outputs are registered and decoded from the next state, so they change on the same edge as the state change.
- PLL_RST
  - pll_rst=1; rst_cnt increments each cycle.
  - At rst_cnt==RESET_CYCLES-1: go to WAIT_LOCK, clear stable_cnt and to_cnt.
  - pll_rst is high for exactly RESET_CYCLES cycles after rst_n deasserts.
- WAIT_LOCK
  - pll_rst=0; to_cnt increments every cycle.
  - stable_cnt increments while lock_s=1 and clears to 0 on any cycle with lock_s=0.
  - At stable_cnt==LOCK_STABLE_CYCLES-1 with lock_s=1: go to STAGE.
  - Otherwise at to_cnt==LOCK_TIMEOUT-1: retries+1. If the new value == MAX_RETRIES, go to FAULT; else go to PLL_RST.
  - Lock completion has priority over timeout in the same cycle.
- STAGE
  - periph_rst_n=1; gap_cnt counts.
  - At gap_cnt==STAGE_GAP-1: go to RUN, core_rst_n=1, ready=1, retries cleared to 0.
- RUN: all domains released.
- Lock loss or relock in STAGE or RUN
  - lock_s=0, or relock_req=1 (in RUN only), at an edge: next state PLL_RST, with periph_rst_n=0, core_rst_n=0, ready=0, pll_rst=1 on that same edge.
  - Lock loss does not increment retries.
  - Simultaneous lock loss and relock_req produce the same single action.
- FAULT
  - pll_rst=1, fault=1, both domain resets asserted, retries held at MAX_RETRIES.
  - Exits only on rst_n low, or on relock_req: go to PLL_RST, retries=0, fault=0.
- relock_req is ignored in PLL_RST, WAIT_LOCK and STAGE.
- Counter widths: clog2 of the relevant parameter. No counter wraps, because each is cleared on state entry.
- Invariant: core_rst_n=1 implies periph_rst_n=1, ready=1 and pll_rst=0 in the same cycle.

Test Plan:
Bench parameters: RESET_CYCLES=4, LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT=32, STAGE_GAP=3, MAX_RETRIES=2.
1. Nominal bring-up: release rst_n, raise locked in the 2nd cycle after pll_rst falls -> pll_rst high 4 cycles; periph_rst_n rises 2+8 cycles after locked rises; core_rst_n and ready rise 3 cycles later; retries=0.
2. Lock glitch: locked high 5 cycles, low 1 cycle, high again -> stable_cnt restarts; periph_rst_n rises 2+8 cycles after the final rise.
3. Timeout/fault: locked held 0 -> two 4-cycle pll_rst pulses separated by 32-cycle WAIT_LOCK periods; retries goes 1 then 2; fault=1 with pll_rst stuck high; a relock_req pulse then clears fault and retries and starts a new 4-cycle pll_rst pulse.
4. Lock loss in RUN: drop locked -> 2 cycles later all resets assert, ready=0 and pll_rst=1 on the same edge; retries unchanged; bring-up repeats when locked returns.
5. relock_req in RUN -> identical response to test 4 on the next edge. relock_req during WAIT_LOCK -> no effect.
6. rst_n low mid-STAGE, coincident with relock_req -> reset values on the next edge and 4-cycle pll_rst after release; relock_req ignored.

Source files
------------

// File: rtl/pll_lock_sequencer_if.sv
// Signal bundle between the PLL lock sequencer and its surroundings.
// master drives lock/relock and observes the reset outputs; slave is the sequencer side.
interface pll_lock_sequencer_if;
  logic       locked;
  logic       relock_req;
  logic       pll_rst;
  logic       periph_rst_n;
  logic       core_rst_n;
  logic       ready;
  logic       fault;
  logic [3:0] retries;

  modport master (
    output locked, relock_req,
    input  pll_rst, periph_rst_n, core_rst_n, ready, fault, retries
  );

  modport slave (
    input  locked, relock_req,
    output pll_rst, periph_rst_n, core_rst_n, ready, fault, retries
  );
endinterface

// File: rtl/pll_lock_sequencer.sv
// PLL reset/lock sequencer: pulses the PLL reset, qualifies lock, releases the
// peripheral then core reset domains, and recovers from lock loss, timeouts and relock requests.
//
// state       | meaning
// ------------+-------------------------------------------------------------
// S_PLL_RST   | PLL held in reset for RESET_CYCLES
// S_WAIT_LOCK | waiting for LOCK_STABLE_CYCLES of steady lock, bounded by LOCK_TIMEOUT
// S_STAGE     | peripheral domain released, core held for STAGE_GAP cycles
// S_RUN       | all domains released
// S_FAULT     | retries exhausted, PLL held in reset until relock_req
module pll_lock_sequencer #(
  parameter int RESET_CYCLES       = 16,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int LOCK_TIMEOUT       = 65536,
  parameter int STAGE_GAP          = 16,
  parameter int MAX_RETRIES        = 3
) (
  input logic                  refclk,
  input logic                  rst_n,
  pll_lock_sequencer_if.slave  bus
);

  localparam int RW = (RESET_CYCLES > 1)       ? $clog2(RESET_CYCLES)       : 1;
  localparam int SW = (LOCK_STABLE_CYCLES > 1) ? $clog2(LOCK_STABLE_CYCLES) : 1;
  localparam int TW = (LOCK_TIMEOUT > 1)       ? $clog2(LOCK_TIMEOUT)       : 1;
  localparam int GW = (STAGE_GAP > 1)          ? $clog2(STAGE_GAP)          : 1;

  localparam logic [RW-1:0] RST_LAST    = RW'(RESET_CYCLES - 1);
  localparam logic [SW-1:0] STABLE_LAST = SW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST     = TW'(LOCK_TIMEOUT - 1);
  localparam logic [GW-1:0] GAP_LAST    = GW'(STAGE_GAP - 1);
  localparam logic [3:0]    MAX_R       = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_PLL_RST,
    S_WAIT_LOCK,
    S_STAGE,
    S_RUN,
    S_FAULT
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic          sync1;
  logic          lock_s;
  logic [RW-1:0] rst_cnt;
  logic [SW-1:0] stable_cnt;
  logic [TW-1:0] to_cnt;
  logic [GW-1:0] gap_cnt;
  logic [3:0]    retries_q;
  logic [3:0]    retries_nxt;
  logic          pll_rst_q;
  logic          periph_rst_n_q;
  logic          core_rst_n_q;
  logic          ready_q;
  logic          fault_q;

  // Lock completion is checked before timeout so a lock on the last cycle still counts.
  always_comb begin
    state_nxt   = state;
    retries_nxt = retries_q;
    case (state)
      S_PLL_RST: begin
        if (rst_cnt == RST_LAST) state_nxt = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        if (lock_s && (stable_cnt == STABLE_LAST)) begin
          state_nxt = S_STAGE;
        end else if (to_cnt == TO_LAST) begin
          retries_nxt = retries_q + 4'd1;
          state_nxt   = ((retries_q + 4'd1) == MAX_R) ? S_FAULT : S_PLL_RST;
        end
      end
      S_STAGE: begin
        if (!lock_s) begin
          state_nxt = S_PLL_RST;
        end else if (gap_cnt == GAP_LAST) begin
          state_nxt   = S_RUN;
          retries_nxt = 4'd0;
        end
      end
      S_RUN: begin
        if (!lock_s || bus.relock_req) state_nxt = S_PLL_RST;
      end
      S_FAULT: begin
        if (bus.relock_req) begin
          state_nxt   = S_PLL_RST;
          retries_nxt = 4'd0;
        end
      end
      default: state_nxt = S_PLL_RST;
    endcase
  end

  // Outputs are decoded from the next state so they switch on the same edge as the state.
  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      state          <= S_PLL_RST;
      sync1          <= 1'b0;
      lock_s         <= 1'b0;
      rst_cnt        <= '0;
      stable_cnt     <= '0;
      to_cnt         <= '0;
      gap_cnt        <= '0;
      retries_q      <= 4'd0;
      pll_rst_q      <= 1'b1;
      periph_rst_n_q <= 1'b0;
      core_rst_n_q   <= 1'b0;
      ready_q        <= 1'b0;
      fault_q        <= 1'b0;
    end else begin
      sync1     <= bus.locked;
      lock_s    <= sync1;
      state     <= state_nxt;
      retries_q <= retries_nxt;
      if (state_nxt != state) begin
        rst_cnt    <= '0;
        stable_cnt <= '0;
        to_cnt     <= '0;
        gap_cnt    <= '0;
      end else begin
        case (state)
          S_PLL_RST:   rst_cnt <= rst_cnt + RW'(1);
          S_WAIT_LOCK: begin
            to_cnt     <= to_cnt + TW'(1);
            stable_cnt <= lock_s ? (stable_cnt + SW'(1)) : '0;
          end
          S_STAGE:     gap_cnt <= gap_cnt + GW'(1);
          default:     ;
        endcase
      end
      pll_rst_q      <= (state_nxt == S_PLL_RST) || (state_nxt == S_FAULT);
      periph_rst_n_q <= (state_nxt == S_STAGE) || (state_nxt == S_RUN);
      core_rst_n_q   <= (state_nxt == S_RUN);
      ready_q        <= (state_nxt == S_RUN);
      fault_q        <= (state_nxt == S_FAULT);
    end
  end

  assign bus.pll_rst      = pll_rst_q;
  assign bus.periph_rst_n = periph_rst_n_q;
  assign bus.core_rst_n   = core_rst_n_q;
  assign bus.ready        = ready_q;
  assign bus.fault        = fault_q;
  assign bus.retries      = retries_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Scoreboard bench for pll_lock_sequencer: a phase/duration reference model queues the
// expected outputs for every refclk edge and a monitor compares them against the DUT.
module tb_pll_lock_sequencer;
  localparam int RC   = 4;
  localparam int LS   = 8;
  localparam int TO   = 32;
  localparam int GAP  = 3;
  localparam int MAXR = 2;

  localparam int PH_PLLRST = 0;
  localparam int PH_WAIT   = 1;
  localparam int PH_STAGE  = 2;
  localparam int PH_RUN    = 3;
  localparam int PH_FAULT  = 4;

  typedef logic [8:0] vec_t;

  logic refclk = 1'b0;
  logic rst_n;

  pll_lock_sequencer_if bus ();

  pll_lock_sequencer #(
    .RESET_CYCLES      (RC),
    .LOCK_STABLE_CYCLES(LS),
    .LOCK_TIMEOUT      (TO),
    .STAGE_GAP         (GAP),
    .MAX_RETRIES       (MAXR)
  ) dut (
    .refclk(refclk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 refclk = ~refclk;

  int   tests = 0;
  int   fails = 0;
  int   edge_n = 0;
  vec_t exp_q[$];
  vec_t mon_exp;
  vec_t mon_act;

  // Reference model: which phase we are in, how long we have been there,
  // how long lock has been continuously seen, and the failed-attempt count.
  int m_phase = PH_PLLRST;
  int m_age   = 0;
  int m_run   = 0;
  int m_fails = 0;
  bit m_d1    = 1'b0;
  bit m_d2    = 1'b0;

  function automatic vec_t model_outputs();
    bit pll, per, core, rdy, flt;
    pll  = (m_phase == PH_PLLRST) || (m_phase == PH_FAULT);
    per  = (m_phase == PH_STAGE) || (m_phase == PH_RUN);
    core = (m_phase == PH_RUN);
    rdy  = (m_phase == PH_RUN);
    flt  = (m_phase == PH_FAULT);
    return {pll, per, core, rdy, flt, 4'(m_fails)};
  endfunction

  task automatic enter(input int ph);
    m_phase = ph;
    m_age   = 0;
    m_run   = 0;
  endtask

  task automatic model_edge(input bit r, input bit l, input bit q);
    bit ls;
    if (!r) begin
      enter(PH_PLLRST);
      m_fails = 0;
      m_d1    = 1'b0;
      m_d2    = 1'b0;
      return;
    end
    ls = m_d2;
    case (m_phase)
      PH_PLLRST: begin
        m_age++;
        if (m_age == RC) enter(PH_WAIT);
      end
      PH_WAIT: begin
        m_age++;
        m_run = ls ? m_run + 1 : 0;
        if (m_run == LS) enter(PH_STAGE);
        else if (m_age == TO) begin
          m_fails++;
          enter((m_fails == MAXR) ? PH_FAULT : PH_PLLRST);
        end
      end
      PH_STAGE: begin
        if (!ls) enter(PH_PLLRST);
        else begin
          m_age++;
          if (m_age == GAP) begin
            enter(PH_RUN);
            m_fails = 0;
          end
        end
      end
      PH_RUN: begin
        if (!ls || q) enter(PH_PLLRST);
      end
      default: begin
        if (q) begin
          enter(PH_PLLRST);
          m_fails = 0;
        end
      end
    endcase
    m_d2 = m_d1;
    m_d1 = l;
  endtask

  task automatic cyc(input bit r, input bit l, input bit q);
    rst_n          = r;
    bus.locked     = l;
    bus.relock_req = q;
    model_edge(r, l, q);
    exp_q.push_back(model_outputs());
    @(posedge refclk);
    #2;
  endtask

  // Monitor: outputs settle right after the edge; compare against the queued expectation.
  initial begin
    forever begin
      @(posedge refclk);
      #1;
      edge_n++;
      if (exp_q.size() > 0) begin
        mon_exp = exp_q.pop_front();
        mon_act = {bus.pll_rst, bus.periph_rst_n, bus.core_rst_n, bus.ready, bus.fault, bus.retries};
        tests++;
        if (mon_act !== mon_exp) begin
          fails++;
          if (fails <= 30)
            $display("FAIL outputs edge %0d: got {pll,per,core,rdy,flt,retries}=%b required %b",
                     edge_n, mon_act, mon_exp);
        end
        if (bus.core_rst_n === 1'b1) begin
          tests++;
          if (!(bus.periph_rst_n === 1'b1 && bus.ready === 1'b1 && bus.pll_rst === 1'b0)) begin
            fails++;
            if (fails <= 30)
              $display("FAIL invariant edge %0d: per=%b rdy=%b pll=%b with core released, required 1 1 0",
                       edge_n, bus.periph_rst_n, bus.ready, bus.pll_rst);
          end
        end
      end
    end
  end

  initial begin
    bit lk;
    bit reached;
    rst_n          = 1'b0;
    bus.locked     = 1'b0;
    bus.relock_req = 1'b0;

    // Reset, then nominal bring-up with lock arriving shortly after pll_rst falls.
    repeat (3) cyc(0, 0, 0);
    repeat (RC + 1) cyc(1, 0, 0);
    repeat (20) cyc(1, 1, 0);

    // Relock from RUN, then a one-cycle lock glitch during WAIT_LOCK.
    cyc(1, 1, 1);
    repeat (RC + 1) cyc(1, 0, 0);
    repeat (5) cyc(1, 1, 0);
    cyc(1, 0, 0);
    repeat (20) cyc(1, 1, 0);

    // Lock lost for good: two timeouts end in FAULT; relock_req restarts.
    repeat (2 * (RC + TO) + 12) cyc(1, 0, 0);
    cyc(1, 0, 1);
    repeat (RC + 2) cyc(1, 0, 0);
    repeat (20) cyc(1, 1, 0);

    // Lock loss in RUN, with one timeout before lock returns.
    repeat (3) cyc(1, 0, 0);
    repeat (RC + TO + 2) cyc(1, 0, 0);
    repeat (25) cyc(1, 1, 0);

    // relock_req in RUN, then relock_req pulses during WAIT_LOCK that must be ignored.
    cyc(1, 1, 1);
    repeat (RC + 2) cyc(1, 1, 0);
    cyc(1, 1, 1);
    cyc(1, 1, 0);
    cyc(1, 1, 1);
    repeat (20) cyc(1, 1, 0);

    // rst_n low mid-STAGE together with relock_req.
    cyc(1, 1, 1);
    reached = 1'b0;
    for (int i = 0; i < 60 && !reached; i++) begin
      cyc(1, 1, 0);
      reached = (m_phase == PH_STAGE);
    end
    tests++;
    if (!reached) begin
      fails++;
      $display("FAIL stage_reach: STAGE not reached within 60 cycles, required reached");
    end
    cyc(1, 1, 0);
    cyc(0, 1, 1);
    repeat (20) cyc(1, 1, 0);

    // Randomized lock behaviour, relock requests and occasional resets.
    lk = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 99) < 4) lk = ~lk;
      cyc(($urandom_range(0, 399) != 0), lk, ($urandom_range(0, 99) < 3));
    end
    repeat (4) cyc(1, 1, 0);

    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
